// File: rtl/tx_frame_builder.sv
// Transmit frame builder: one header beat per descriptor, then payload beats from s_axis
// with generated tkeep/tlast, through a single-register output stage.
module tx_frame_builder #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [31:0]           desc_dest_ip,
  input  logic [15:0]           desc_dest_port,
  input  logic [31:0]           desc_hash,
  input  logic [15:0]           desc_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  err_len
);

  // Byte offset within a beat; KEEP_WIDTH is expected to be a power of two.
  localparam int unsigned RemW = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StPayload, StDrain} state_e;

  state_e                state_q, state_d;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0] m_keep_q;
  logic                  m_last_q;
  logic [15:0]           cnt_q;
  logic [RemW-1:0]       rem_q;
  logic [15:0]           frame_cnt_q;
  logic                  err_q;

  logic                  out_en;
  logic                  desc_hs;
  logic                  s_hs;
  logic                  pay_hs;
  logic                  final_beat;
  logic                  err_d;
  logic [16:0]           len_round;
  logic [15:0]           beats;
  logic [DATA_WIDTH-1:0] hdr;
  logic [KEEP_WIDTH-1:0] last_keep;

  assign out_en     = !m_valid_q || m_axis_tready;
  assign desc_hs    = desc_valid && desc_ready;
  assign s_hs       = s_axis_tvalid && s_axis_tready;
  assign pay_hs     = s_hs && (state_q == StPayload);
  assign final_beat = (cnt_q == 16'd1);
  // A zero remainder means the last beat is full.
  assign last_keep  = (rem_q == '0) ? '1 : ~({KEEP_WIDTH{1'b1}} << rem_q);

  // Beat count and header image for the presented descriptor.
  always_comb begin
    len_round      = {1'b0, desc_len} + 17'(KEEP_WIDTH - 1);
    beats          = 16'(len_round / 17'(KEEP_WIDTH));
    hdr            = '0;
    hdr[31:0]      = desc_dest_ip;
    hdr[47:32]     = desc_dest_port;
    hdr[63:48]     = desc_len;
    hdr[95:64]     = desc_hash;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (desc_hs && (desc_len != 16'd0)) state_d = StPayload;
      end
      StPayload: begin
        if (s_hs) begin
          if (final_beat)        state_d = s_axis_tlast ? StIdle : StDrain;
          else if (s_axis_tlast) state_d = StIdle;
        end
      end
      StDrain: begin
        if (s_hs && s_axis_tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs; all held low while in reset.
  always_comb begin
    desc_ready    = 1'b0;
    s_axis_tready = 1'b0;
    busy          = 1'b0;
    err_d         = 1'b0;
    if (rst) begin
      desc_ready    = (state_q == StIdle) && out_en;
      s_axis_tready = ((state_q == StPayload) && out_en) || (state_q == StDrain);
      busy          = (state_q != StIdle) || m_valid_q;
      // Mismatch: source ends early, or source runs past the descriptor length.
      err_d         = pay_hs && (final_beat != s_axis_tlast);
    end
  end

  // Output register, beat counter, frame counter and error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_d;
      if (m_valid_q && m_axis_tready && m_last_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (desc_hs) begin
        cnt_q <= beats;
        rem_q <= desc_len[RemW-1:0];
      end else if (pay_hs) begin
        cnt_q <= cnt_q - 16'd1;
      end
      if (out_en) begin
        if (desc_hs) begin
          m_valid_q <= 1'b1;
          m_data_q  <= hdr;
          m_keep_q  <= '1;
          m_last_q  <= (desc_len == 16'd0);
        end else if (pay_hs) begin
          m_valid_q <= 1'b1;
          m_data_q  <= s_axis_tdata;
          m_keep_q  <= final_beat ? last_keep : '1;
          m_last_q  <= final_beat || s_axis_tlast;
        end else begin
          m_valid_q <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign frame_count   = frame_cnt_q;
  assign err_len       = err_q;

endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed bench for tx_frame_builder with a beat-queue reference model.
module tb_tx_frame_builder;

  localparam int unsigned DW = 256;
  localparam int unsigned KW = DW / 8;

  logic          clk;
  logic          rst;
  logic          desc_valid;
  logic          desc_ready;
  logic [31:0]   desc_dest_ip;
  logic [15:0]   desc_dest_port;
  logic [31:0]   desc_hash;
  logic [15:0]   desc_len;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic [15:0]   frame_count;
  logic          err_len;

  tx_frame_builder #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .clk            (clk),
    .rst            (rst),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_dest_ip   (desc_dest_ip),
    .desc_dest_port (desc_dest_port),
    .desc_hash      (desc_hash),
    .desc_len       (desc_len),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .frame_count    (frame_count),
    .err_len        (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  beat_t cap_q[$];

  int tests = 0;
  int fails = 0;
  int exp_fc = 0;
  int exp_err = 0;
  int err_cnt = 0;
  int md_mode = 0;  // 0 idle, 1 payload, 2 drain
  int md_beats = 0;
  int md_k = 0;
  int md_rem = 0;
  logic tog_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every cycle out of reset, check the frame counter, and on each
  // output handshake check the beat against the model queue; stalled beats must hold.
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_d;
  logic [KW-1:0] stall_k;
  logic          stall_l;
  always @(negedge clk) begin
    if (!rst) begin
      stall_q = 1'b0;
    end else begin
      chk("frame_count", DW'(frame_count), DW'(exp_fc[15:0]));
      if (err_len) err_cnt++;
      if (stall_q) begin
        chk("stall valid held", DW'(m_axis_tvalid), DW'(1));
        chk("stall data held", m_axis_tdata, stall_d);
        chk("stall keep held", DW'(m_axis_tkeep), DW'(stall_k));
        chk("stall last held", DW'(m_axis_tlast), DW'(stall_l));
      end
      stall_q = m_axis_tvalid && !m_axis_tready;
      stall_d = m_axis_tdata;
      stall_k = m_axis_tkeep;
      stall_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        beat_t e;
        beat_t c;
        c.d = m_axis_tdata;
        c.k = m_axis_tkeep;
        c.l = m_axis_tlast;
        cap_q.push_back(c);
        chk("beat expected", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat tdata", c.d, e.d);
          chk("beat tkeep", DW'(c.k), DW'(e.k));
          chk("beat tlast", DW'(c.l), DW'(e.l));
          if (e.l) exp_fc = (exp_fc + 1) % 65536;
        end
      end
    end
  end

  // Ready toggler used for the stall test.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) m_axis_tready = !m_axis_tready;
    end
  end

  task automatic send_desc(input logic [31:0] ip, input logic [15:0] port,
                           input logic [31:0] hash, input logic [15:0] len);
    beat_t b;
    logic got = 1'b0;
    desc_dest_ip   = ip;
    desc_dest_port = port;
    desc_hash      = hash;
    desc_len       = len;
    desc_valid     = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (desc_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
    chk("desc_ready timeout", DW'(got), DW'(1));
    b.d        = '0;
    b.d[31:0]  = ip;
    b.d[47:32] = port;
    b.d[63:48] = len;
    b.d[95:64] = hash;
    b.k        = '1;
    b.l        = (len == 16'd0);
    exp_q.push_back(b);
    md_beats = (int'(len) + KW - 1) / KW;
    md_rem   = int'(len) % KW;
    md_k     = 0;
    md_mode  = (len == 16'd0) ? 0 : 1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic tl);
    beat_t b;
    logic got = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = tl;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("s_axis_tready timeout", DW'(got), DW'(1));
    if (md_mode == 1) begin
      md_k++;
      b.d = d;
      if (md_k == md_beats) begin
        b.l = 1'b1;
        b.k = (md_rem == 0) ? '1 : KW'((32'h1 << md_rem) - 32'h1);
        if (!tl) exp_err++;
        md_mode = tl ? 0 : 2;
      end else if (tl) begin
        b.l = 1'b1;
        b.k = '1;
        exp_err++;
        md_mode = 0;
      end else begin
        b.l = 1'b0;
        b.k = '1;
      end
      exp_q.push_back(b);
    end else if (md_mode == 2) begin
      if (tl) md_mode = 0;
    end
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain timeout", DW'(done), DW'(1));
    chk("model left payload", DW'(md_mode), DW'(0));
    chk("err_len pulses", DW'(err_cnt), DW'(exp_err));
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    cap_q.delete();
    err_cnt = 0;
    exp_err = 0;
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] v);
    return {KW{v}};
  endfunction

  initial begin
    rst            = 1'b0;
    desc_valid     = 1'b0;
    desc_dest_ip   = '0;
    desc_dest_port = '0;
    desc_hash      = '0;
    desc_len       = '0;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    m_axis_tready  = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst m_axis_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst m_axis_tdata", m_axis_tdata, '0);
    chk("rst m_axis_tkeep", DW'(m_axis_tkeep), DW'(0));
    chk("rst m_axis_tlast", DW'(m_axis_tlast), DW'(0));
    chk("rst frame_count", DW'(frame_count), DW'(0));
    chk("rst err_len", DW'(err_len), DW'(0));
    chk("rst desc_ready", DW'(desc_ready), DW'(0));
    chk("rst s_axis_tready", DW'(s_axis_tready), DW'(0));
    chk("rst busy", DW'(busy), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // len=64: header plus two full beats.
    start_test();
    send_desc(32'hC0A80001, 16'h0016, 32'h12345678, 16'd64);
    send_beat(fill(8'hAA), 1'b0);
    send_beat(fill(8'hAA), 1'b1);
    wait_idle();
    chk("t1 beats", DW'(cap_q.size()), DW'(3));
    chk("t1 header", DW'(cap_q[0].d[95:0]), DW'(96'h12345678_0040_0016_C0A80001));
    chk("t1 header upper", DW'(cap_q[0].d[DW-1:96]), '0);
    chk("t1 beat2 keep", DW'(cap_q[2].k), DW'(32'hFFFFFFFF));
    chk("t1 beat2 last", DW'(cap_q[2].l), DW'(1));
    chk("t1 frame_count", DW'(frame_count), DW'(1));

    // len=40: partial last beat.
    start_test();
    send_desc(32'h0A000001, 16'h1F90, 32'hDEADBEEF, 16'd40);
    send_beat(fill(8'h11), 1'b0);
    send_beat(fill(8'h22), 1'b1);
    wait_idle();
    chk("t2 beat2 keep", DW'(cap_q[2].k), DW'(32'h000000FF));
    chk("t2 beat2 last", DW'(cap_q[2].l), DW'(1));
    chk("t2 err_len", DW'(err_cnt), DW'(0));

    // len=0: header only, source never accepted.
    start_test();
    send_desc(32'h01020304, 16'h0050, 32'hCAFEF00D, 16'd0);
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3 s_axis_tready", DW'(s_axis_tready), DW'(0));
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    wait_idle();
    chk("t3 beats", DW'(cap_q.size()), DW'(1));
    chk("t3 header last", DW'(cap_q[0].l), DW'(1));
    chk("t3 frame_count", DW'(frame_count), DW'(3));

    // Stalled output: ready toggles through a 3-beat payload.
    start_test();
    tog_en = 1'b1;
    send_desc(32'hAC100001, 16'h0035, 32'h0BADF00D, 16'd96);
    send_beat(fill(8'hA1), 1'b0);
    send_beat(fill(8'hA2), 1'b0);
    send_beat(fill(8'hA3), 1'b1);
    wait_idle();
    tog_en = 1'b0;
    m_axis_tready = 1'b1;
    chk("t4 beats", DW'(cap_q.size()), DW'(4));
    chk("t4 beat3 data", cap_q[3].d, fill(8'hA3));

    // Short source: tlast on beat 2 of 3, then a follow-up frame.
    start_test();
    send_desc(32'hC0A80002, 16'h0017, 32'h00000001, 16'd96);
    send_beat(fill(8'hB1), 1'b0);
    send_beat(fill(8'hB2), 1'b1);
    wait_idle();
    chk("t5a err_len once", DW'(err_cnt), DW'(1));
    chk("t5a beat2 last", DW'(cap_q[2].l), DW'(1));
    chk("t5a beat2 keep", DW'(cap_q[2].k), DW'(32'hFFFFFFFF));
    start_test();
    send_desc(32'hC0A80003, 16'h0018, 32'h00000002, 16'd32);
    send_beat(fill(8'hB3), 1'b1);
    wait_idle();
    chk("t5a next frame beats", DW'(cap_q.size()), DW'(2));

    // Long source: len=32 with tlast on source beat 3; beats 2-3 drained.
    start_test();
    send_desc(32'hC0A80004, 16'h0019, 32'h00000003, 16'd32);
    send_beat(fill(8'hC1), 1'b0);
    send_beat(fill(8'hC2), 1'b0);
    send_beat(fill(8'hC3), 1'b1);
    wait_idle();
    chk("t5b err_len once", DW'(err_cnt), DW'(1));
    chk("t5b beats", DW'(cap_q.size()), DW'(2));
    chk("t5b frame_count", DW'(frame_count), DW'(7));

    // Reset mid-payload, then a clean frame.
    start_test();
    send_desc(32'hC0A80005, 16'h001A, 32'h00000004, 16'd96);
    send_beat(fill(8'hD1), 1'b0);
    rst = 1'b0;
    exp_q.delete();
    md_mode = 0;
    exp_fc  = 0;
    @(negedge clk);
    chk("t6 busy in reset", DW'(busy), DW'(0));
    chk("t6 desc_ready in reset", DW'(desc_ready), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6 m_axis_tvalid after reset", DW'(m_axis_tvalid), DW'(0));
    chk("t6 frame_count after reset", DW'(frame_count), DW'(0));
    @(posedge clk);
    #1;
    start_test();
    send_desc(32'hC0A80006, 16'h001B, 32'h00000005, 16'd64);
    send_beat(fill(8'hE1), 1'b0);
    send_beat(fill(8'hE2), 1'b1);
    wait_idle();
    chk("t6 clean beats", DW'(cap_q.size()), DW'(3));
    chk("t6 frame_count", DW'(frame_count), DW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
